// File: rtl/cache_pkg.sv
// Types and default widths shared between the direct-mapped cache core and its write-back buffer.
package cache_pkg;

    localparam int unsigned ADDR_WIDTH  = 13;
    localparam int unsigned DATA_WIDTH  = 64;
    localparam int unsigned INDEX_WIDTH = 8;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_age_match.sv
// Associative match of one lookup address against buffer entries, scanned oldest to youngest
// so the last match found (closest to tail) wins.
module wb_age_match #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic [DEPTH-1:0]                 valid_i,
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_i,
    input  logic [$clog2(DEPTH)-1:0]         head_i,
    input  logic [ADDR_WIDTH-1:0]            lookup_addr_i,
    output logic                             hit_c_o,
    output logic [$clog2(DEPTH)-1:0]         idx_c_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] slot;

    always_comb begin
        hit_c_o = 1'b0;
        idx_c_o = head_i;
        slot    = head_i;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            slot = head_i + PW'(k);
            if (valid_i[slot] && (addr_i[slot] == lookup_addr_i)) begin
                hit_c_o = 1'b1;
                idx_c_o = slot;
            end
        end
    end

endmodule

// File: rtl/wb_victim_buffer.sv
// Dirty-victim write-back FIFO: multi-port capture of evicted lines, in-order drain to memory,
// and associative lookup of lines not yet written back.
module wb_victim_buffer #(
    parameter int unsigned WR_PORT_NUM = 2,
    parameter int unsigned RD_PORT_NUM = 2,
    parameter int unsigned ADDR_WIDTH  = cache_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = cache_pkg::DATA_WIDTH,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [WR_PORT_NUM-1:0]                 evict,
    input  logic [WR_PORT_NUM-1:0]                 evicted_dirty,
    input  logic [WR_PORT_NUM-1:0][ADDR_WIDTH-1:0] evicted_addr,
    input  logic [WR_PORT_NUM-1:0][DATA_WIDTH-1:0] evicted_data,
    output logic                                   wb_ready,
    input  logic [RD_PORT_NUM-1:0][ADDR_WIDTH-1:0] lookup_addr,
    output logic [RD_PORT_NUM-1:0]                 lookup_hit,
    output logic [RD_PORT_NUM-1:0][DATA_WIDTH-1:0] lookup_data,
    output logic                                   mem_req_valid,
    output logic [ADDR_WIDTH-1:0]                  mem_req_addr,
    output logic [DATA_WIDTH-1:0]                  mem_req_data,
    input  logic                                   mem_req_ready,
    output logic [$clog2(DEPTH):0]                 count,
    output logic                                   empty,
    output logic                                   overflow
);

    import cache_pkg::wb_entry_t;

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t      entry_q [DEPTH];
    wb_entry_t      entry_d [DEPTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;

    logic [WR_PORT_NUM-1:0] enq_req;
    logic [CW-1:0]          n_enq;
    logic [CW-1:0]          free_slots;
    logic                   enq_ok;
    logic                   pop;
    logic [PW-1:0]          wr_off;
    logic [PW-1:0]          wr_idx;

    assign enq_req    = evict & evicted_dirty;
    assign free_slots = CW'(DEPTH) - count_q;
    assign pop        = mem_req_valid & mem_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= entry_d[i];
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Space is judged on the registered count, so a slot freed by this cycle's pop is not reused.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) entry_d[i] = entry_q[i];
        head_d     = head_q;
        tail_d     = tail_q;
        overflow_d = overflow_q;
        n_enq      = '0;
        wr_off     = '0;
        wr_idx     = tail_q;

        for (int i = 0; i < int'(WR_PORT_NUM); i++) n_enq = n_enq + CW'(enq_req[i]);
        enq_ok = (n_enq <= free_slots);

        if (pop) begin
            entry_d[head_q].valid = 1'b0;
            head_d                = head_q + PW'(1);
        end

        if (enq_ok) begin
            for (int i = 0; i < int'(WR_PORT_NUM); i++) begin
                if (enq_req[i]) begin
                    wr_idx                = tail_q + wr_off;
                    entry_d[wr_idx].valid = 1'b1;
                    entry_d[wr_idx].addr  = evicted_addr[i];
                    entry_d[wr_idx].data  = evicted_data[i];
                    wr_off                = wr_off + PW'(1);
                end
            end
            tail_d = tail_q + PW'(n_enq);
        end else begin
            overflow_d = 1'b1;
        end

        count_d = count_q + (enq_ok ? n_enq : CW'(0)) - CW'(pop);
    end

    assign mem_req_valid = entry_q[head_q].valid;
    assign mem_req_addr  = entry_q[head_q].addr;
    assign mem_req_data  = entry_q[head_q].data;
    assign count         = count_q;
    assign empty         = (count_q == '0);
    assign overflow      = overflow_q;
    assign wb_ready      = (free_slots >= CW'(WR_PORT_NUM));

    logic [DEPTH-1:0]                 ent_valid;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr;

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            ent_valid[i] = entry_q[i].valid;
            ent_addr[i]  = entry_q[i].addr;
        end
    end

    for (genvar r = 0; r < int'(RD_PORT_NUM); r++) begin : g_lookup
        logic          hit_c;
        logic [PW-1:0] idx_c;

        wb_age_match #(
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_match (
            .valid_i       (ent_valid),
            .addr_i        (ent_addr),
            .head_i        (head_q),
            .lookup_addr_i (lookup_addr[r]),
            .hit_c_o       (hit_c),
            .idx_c_o       (idx_c)
        );

        assign lookup_hit[r]  = hit_c;
        assign lookup_data[r] = hit_c ? entry_q[idx_c].data : '0;
    end

endmodule

// File: tb/tb_wb_victim_buffer.sv
// Directed bench for wb_victim_buffer: capture, drain order, lookup, overflow, wrap and async reset.
module tb_wb_victim_buffer;

    logic             clk;
    logic             rst_n;
    logic [1:0]       evict;
    logic [1:0]       evicted_dirty;
    logic [1:0][12:0] evicted_addr;
    logic [1:0][63:0] evicted_data;
    logic             wb_ready;
    logic [1:0][12:0] lookup_addr;
    logic [1:0]       lookup_hit;
    logic [1:0][63:0] lookup_data;
    logic             mem_req_valid;
    logic [12:0]      mem_req_addr;
    logic [63:0]      mem_req_data;
    logic             mem_req_ready;
    logic [2:0]       count;
    logic             empty;
    logic             overflow;

    int checks;
    int failures;

    wb_victim_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .evict         (evict),
        .evicted_dirty (evicted_dirty),
        .evicted_addr  (evicted_addr),
        .evicted_data  (evicted_data),
        .wb_ready      (wb_ready),
        .lookup_addr   (lookup_addr),
        .lookup_hit    (lookup_hit),
        .lookup_data   (lookup_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_ready (mem_req_ready),
        .count         (count),
        .empty         (empty),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ev(input int p, input logic dirty, input logic [12:0] a, input logic [63:0] d);
        evict[p]         = 1'b1;
        evicted_dirty[p] = dirty;
        evicted_addr[p]  = a;
        evicted_data[p]  = d;
    endtask

    task automatic clr_ev();
        evict         = '0;
        evicted_dirty = '0;
        evicted_addr  = '0;
        evicted_data  = '0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        mem_req_ready = 1'b0;
        lookup_addr   = '0;
        clr_ev();

        // reset state
        #2;
        check_eq("rst_valid", 64'(mem_req_valid), 64'd0);
        check_eq("rst_empty", 64'(empty), 64'd1);
        check_eq("rst_ready", 64'(wb_ready), 64'd1);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        check_eq("rst_hit", 64'(lookup_hit), 64'd0);
        check_eq("rst_ldata", lookup_data[0], 64'd0);
        #10 rst_n = 1'b1;
        step();

        // single dirty evict, held head, then pop
        set_ev(0, 1'b1, 13'h0123, 64'hDEADBEEF_CAFEF00D);
        step();
        clr_ev();
        check_eq("t1_valid", 64'(mem_req_valid), 64'd1);
        check_eq("t1_addr", 64'(mem_req_addr), 64'h0123);
        check_eq("t1_count", 64'(count), 64'd1);
        for (int c = 0; c < 5; c++) begin
            step();
            check_eq("t1_hold_addr", 64'(mem_req_addr), 64'h0123);
            check_eq("t1_hold_data", mem_req_data, 64'hDEADBEEF_CAFEF00D);
        end
        mem_req_ready  = 1'b1;
        lookup_addr[0] = 13'h0123;
        #1;
        check_eq("t1_pop_hit", 64'(lookup_hit[0]), 64'd1);
        step();
        mem_req_ready = 1'b0;
        check_eq("t1_empty", 64'(empty), 64'd1);
        check_eq("t1_novalid", 64'(mem_req_valid), 64'd0);

        // two dirty ports in one cycle, clean victims ignored
        set_ev(0, 1'b1, 13'h0010, 64'h10);
        set_ev(1, 1'b1, 13'h0020, 64'h20);
        step();
        clr_ev();
        set_ev(0, 1'b0, 13'h0030, 64'h30);
        set_ev(1, 1'b0, 13'h0030, 64'h30);
        step();
        clr_ev();
        check_eq("t2_count", 64'(count), 64'd2);
        check_eq("t2_head0", 64'(mem_req_addr), 64'h0010);
        mem_req_ready = 1'b1;
        step();
        check_eq("t2_head1", 64'(mem_req_addr), 64'h0020);
        check_eq("t2_cnt1", 64'(count), 64'd1);
        step();
        mem_req_ready = 1'b0;
        check_eq("t2_empty", 64'(empty), 64'd1);

        // duplicate addresses: youngest wins on lookup, oldest drains first
        set_ev(0, 1'b1, 13'h0055, 64'hAAAA);
        step();
        clr_ev();
        set_ev(1, 1'b1, 13'h0055, 64'hBBBB);
        step();
        clr_ev();
        lookup_addr[0] = 13'h0055;
        lookup_addr[1] = 13'h0056;
        #1;
        check_eq("t3_hit0", 64'(lookup_hit[0]), 64'd1);
        check_eq("t3_data0", lookup_data[0], 64'hBBBB);
        check_eq("t3_hit1", 64'(lookup_hit[1]), 64'd0);
        check_eq("t3_data1", lookup_data[1], 64'd0);
        check_eq("t3_headA", mem_req_data, 64'hAAAA);
        mem_req_ready = 1'b1;
        step();
        check_eq("t3_headB", mem_req_data, 64'hBBBB);
        check_eq("t3_hitB", lookup_data[0], 64'hBBBB);
        step();
        mem_req_ready = 1'b0;
        check_eq("t3_empty", 64'(empty), 64'd1);
        check_eq("t3_miss", 64'(lookup_hit[0]), 64'd0);

        // fill to 3, overflow drops whole cycle, sticky, pop still proceeds
        set_ev(0, 1'b1, 13'h0001, 64'h1);
        set_ev(1, 1'b1, 13'h0002, 64'h2);
        step();
        clr_ev();
        check_eq("t4_cnt2", 64'(count), 64'd2);
        check_eq("t4_rdy2", 64'(wb_ready), 64'd1);
        set_ev(0, 1'b1, 13'h0003, 64'h3);
        step();
        clr_ev();
        check_eq("t4_cnt3", 64'(count), 64'd3);
        check_eq("t4_rdy3", 64'(wb_ready), 64'd0);
        set_ev(0, 1'b1, 13'h0004, 64'h4);
        set_ev(1, 1'b1, 13'h0005, 64'h5);
        step();
        clr_ev();
        lookup_addr[0] = 13'h0004;
        #1;
        check_eq("t4_ovf", 64'(overflow), 64'd1);
        check_eq("t4_cnt_drop", 64'(count), 64'd3);
        check_eq("t4_dropped", 64'(lookup_hit[0]), 64'd0);
        set_ev(0, 1'b1, 13'h0006, 64'h6);
        set_ev(1, 1'b1, 13'h0007, 64'h7);
        mem_req_ready = 1'b1;
        step();
        clr_ev();
        check_eq("t4_cnt_pop", 64'(count), 64'd2);
        check_eq("t4_head", 64'(mem_req_addr), 64'h0002);
        step();
        check_eq("t4_head3", 64'(mem_req_addr), 64'h0003);
        step();
        mem_req_ready = 1'b0;
        check_eq("t4_empty", 64'(empty), 64'd1);
        check_eq("t4_sticky", 64'(overflow), 64'd1);

        // exactly full: two pairs accepted
        set_ev(0, 1'b1, 13'h000A, 64'hA);
        set_ev(1, 1'b1, 13'h000B, 64'hB);
        step();
        set_ev(0, 1'b1, 13'h000C, 64'hC);
        set_ev(1, 1'b1, 13'h000D, 64'hD);
        step();
        clr_ev();
        lookup_addr[1] = 13'h000D;
        #1;
        check_eq("full_cnt", 64'(count), 64'd4);
        check_eq("full_rdy", 64'(wb_ready), 64'd0);
        check_eq("full_look", lookup_data[1], 64'hD);
        mem_req_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        mem_req_ready = 1'b0;
        check_eq("full_empty", 64'(empty), 64'd1);

        // steady enqueue+pop at count 2, wrapping pointers over 10 entries
        set_ev(0, 1'b1, 13'd0, 64'd0);
        set_ev(1, 1'b1, 13'd1, 64'd1);
        step();
        clr_ev();
        mem_req_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_ev(0, 1'b1, 13'(k + 2), 64'(k + 2));
            #1;
            check_eq("t5_head", 64'(mem_req_addr), 64'(k));
            step();
            check_eq("t5_cnt", 64'(count), 64'd2);
        end
        clr_ev();
        check_eq("t5_head8", 64'(mem_req_addr), 64'd8);
        step();
        check_eq("t5_head9", 64'(mem_req_data), 64'd9);
        step();
        mem_req_ready = 1'b0;
        check_eq("t5_empty", 64'(empty), 64'd1);

        // async reset mid-drain discards everything
        set_ev(0, 1'b1, 13'h0100, 64'h100);
        set_ev(1, 1'b1, 13'h0101, 64'h101);
        step();
        clr_ev();
        set_ev(0, 1'b1, 13'h0102, 64'h102);
        step();
        clr_ev();
        check_eq("t6_cnt3", 64'(count), 64'd3);
        mem_req_ready  = 1'b1;
        lookup_addr[0] = 13'h0101;
        #2;
        check_eq("t6_prehit", 64'(lookup_hit[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_valid", 64'(mem_req_valid), 64'd0);
        check_eq("t6_count", 64'(count), 64'd0);
        check_eq("t6_ovf", 64'(overflow), 64'd0);
        check_eq("t6_hit", 64'(lookup_hit[0]), 64'd0);
        step();
        rst_n         = 1'b1;
        mem_req_ready = 1'b0;
        step();
        check_eq("t6_empty", 64'(empty), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
